// File: rtl/world_loader.sv
// world_loader: turns a sync-framed UART byte stream into voxel cache writes.
// Coordinates advance z-fastest, and a trailing XOR checksum validates the frame.
`timescale 1ns/1ps
module world_loader #(
  parameter int         LENGTH    = 64,
  parameter int         WIDTH     = 64,
  parameter int         HEIGHT    = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  localparam int        XW        = $clog2(LENGTH),
  localparam int        YW        = $clog2(WIDTH),
  localparam int        ZW        = $clog2(HEIGHT)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [7:0]    uart_data_in,
  input  logic          uart_valid_in,
  input  logic          start_in,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [ZW-1:0] z_out,
  output logic [4:0]    block_data_out,
  output logic          write_out,
  output logic          busy_out,
  output logic          done_out,
  output logic          error_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SYNC    = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_CHECK   = 2'd3;

  logic [1:0]    r_state;
  logic [XW-1:0] r_x_cnt;
  logic [YW-1:0] r_y_cnt;
  logic [ZW-1:0] r_z_cnt;
  logic [7:0]    r_acc;

  logic [XW-1:0] r_x_out;
  logic [YW-1:0] r_y_out;
  logic [ZW-1:0] r_z_out;
  logic [4:0]    r_block;
  logic          r_write;
  logic          r_done;
  logic          r_error;

  logic w_accept;
  logic w_sync_hit;
  logic w_pay_byte;
  logic w_chk_byte;
  logic w_x_last;
  logic w_y_last;
  logic w_z_last;
  logic w_frame_last;

  // A byte arriving together with start_in is dropped: the restart takes priority.
  assign w_accept     = uart_valid_in & ~start_in;
  assign w_sync_hit   = w_accept && (r_state == S_SYNC) && (uart_data_in == SYNC_BYTE);
  assign w_pay_byte   = w_accept && (r_state == S_PAYLOAD);
  assign w_chk_byte   = w_accept && (r_state == S_CHECK);

  assign w_x_last     = (r_x_cnt == XW'(LENGTH - 1));
  assign w_y_last     = (r_y_cnt == YW'(WIDTH - 1));
  assign w_z_last     = (r_z_cnt == ZW'(HEIGHT - 1));
  assign w_frame_last = w_x_last & w_y_last & w_z_last;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else if (start_in) begin
      r_state <= S_SYNC;
    end else begin
      case (r_state)
        S_SYNC:    if (w_sync_hit) r_state <= S_PAYLOAD;
        S_PAYLOAD: if (w_pay_byte && w_frame_last) r_state <= S_CHECK;
        S_CHECK:   if (w_chk_byte) r_state <= S_IDLE;
        default:   r_state <= r_state;
      endcase
    end
  end

  // Ripple-carry coordinate counters; x wraps naturally since LENGTH is a power of two.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_x_cnt <= '0;
      r_y_cnt <= '0;
      r_z_cnt <= '0;
    end else if (w_sync_hit) begin
      r_x_cnt <= '0;
      r_y_cnt <= '0;
      r_z_cnt <= '0;
    end else if (w_pay_byte) begin
      if (w_z_last) begin
        r_z_cnt <= '0;
        if (w_y_last) begin
          r_y_cnt <= '0;
          r_x_cnt <= r_x_cnt + 1'b1;
        end else begin
          r_y_cnt <= r_y_cnt + 1'b1;
        end
      end else begin
        r_z_cnt <= r_z_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_acc <= '0;
    end else if (w_sync_hit) begin
      r_acc <= '0;
    end else if (w_pay_byte) begin
      r_acc <= r_acc ^ uart_data_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_write <= 1'b0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_z_out <= '0;
      r_block <= '0;
    end else begin
      r_write <= w_pay_byte;
      if (w_pay_byte) begin
        r_x_out <= r_x_cnt;
        r_y_out <= r_y_cnt;
        r_z_out <= r_z_cnt;
        r_block <= uart_data_in[4:0];
      end
    end
  end

  // error_out is sticky across frames until the next start_in re-arms the loader.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done <= w_chk_byte;
      if (start_in) begin
        r_error <= 1'b0;
      end else if (w_chk_byte) begin
        r_error <= (uart_data_in != r_acc);
      end
    end
  end

  assign x_out          = r_x_out;
  assign y_out          = r_y_out;
  assign z_out          = r_z_out;
  assign block_data_out = r_block;
  assign write_out      = r_write;
  assign done_out       = r_done;
  assign error_out      = r_error;
  assign busy_out       = (r_state != S_IDLE);

endmodule
